connect4_move_ctrl: RTL and testbench

- Upstream stage of the winner detector.
- Owns the 4x4 Connect-4 board state, accepts column-drop requests from the input/debounce logic, and applies gravity and turn alternation.
- Drives the `game_board`/`player_cells` vectors consumed by the winner detector.
- Samples the returned `game_status` to lock the board once a win or tie is reported.

---
 rtl/connect4_pkg.sv | 33 +++
 rtl/connect4_move_ctrl_drop_locator.sv | 44 ++++
 rtl/connect4_move_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_connect4_move_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// -----------------------------------------------------------------------------
// connect4_pkg
// Shared definitions for the 4x4 Connect-4 move controller and the winner
// detector: board geometry, game status encodings, controller FSM states and
// the row/column to cell-index mapping.
// Cell index convention: index = row*4 + col, row 0 is the bottom row.
// -----------------------------------------------------------------------------
package connect4_pkg;

    localparam int unsigned BOARD_CELLS = 16;
    localparam int unsigned BOARD_COLS  = 4;
    localparam int unsigned BOARD_ROWS  = 4;

    // Status reported back by the winner detector.
    localparam logic [1:0] STILL_PLAYING = 2'b00;
    localparam logic [1:0] P1_WINS       = 2'b01;
    localparam logic [1:0] P2_WINS       = 2'b10;
    localparam logic [1:0] TIE           = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOCATE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_OVER   = 3'd4
    } c4_state_e;

    // Cell index from row and column; row occupies the upper two bits.
    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/connect4_move_ctrl_drop_locator.sv
// -----------------------------------------------------------------------------
// drop_locator
// Combinational gravity search: for the selected column, finds the lowest
// empty cell and reports whether the column is already full.
// Ports:
//   col_i   [1:0]  column to drop into
//   board_i [15:0] occupancy vector (bit = row*4 + col)
//   idx_o   [3:0]  cell index where the piece lands (top cell when full)
//   full_o         column has no empty cell
// -----------------------------------------------------------------------------
module drop_locator
    import connect4_pkg::*;
(
    input  logic [1:0]  col_i,
    input  logic [15:0] board_i,
    output logic [3:0]  idx_o,
    output logic        full_o
);

    logic [3:0] col_bits_s;  // occupancy of the selected column, bit = row

    assign col_bits_s[0] = board_i[cell_index(2'd0, col_i)];
    assign col_bits_s[1] = board_i[cell_index(2'd1, col_i)];
    assign col_bits_s[2] = board_i[cell_index(2'd2, col_i)];
    assign col_bits_s[3] = board_i[cell_index(2'd3, col_i)];

    // Lowest empty row wins; gravity keeps each column contiguous from row 0.
    always_comb begin
        idx_o  = cell_index(2'd3, col_i);
        full_o = 1'b0;
        if (!col_bits_s[0]) begin
            idx_o = cell_index(2'd0, col_i);
        end else if (!col_bits_s[1]) begin
            idx_o = cell_index(2'd1, col_i);
        end else if (!col_bits_s[2]) begin
            idx_o = cell_index(2'd2, col_i);
        end else if (!col_bits_s[3]) begin
            idx_o = cell_index(2'd3, col_i);
        end else begin
            full_o = 1'b1;
        end
    end

endmodule

// File: rtl/connect4_move_ctrl.sv
// -----------------------------------------------------------------------------
// connect4_move_ctrl
// Owns the 4x4 Connect-4 board. Accepts column drops, applies gravity and
// turn alternation, publishes the board to the winner detector and locks the
// board once the detector reports a win or tie.
//
// Optional feature macro: CONNECT4_UNDO_EN (single-level undo). When it is
// not defined, undo_req is ignored, undo_ack is tied low and no undo flag
// register exists.
//
// Parameters:
//   SETTLE_CYCLES  cycles between board write and status sample (>= 1)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   new_game             synchronous clear, highest priority
//   move_valid/move_col  drop request and column
//   move_ready           high only in IDLE
//   move_ack / move_err  1-cycle pulses: piece placed / column full
//   undo_req / undo_ack  undo request / 1-cycle undo-applied pulse
//   game_status          detector status (00 playing, 01 P1, 10 P2, 11 tie)
//   game_board           occupancy, bit = row*4 + col
//   player_cells         owner of each occupied cell (0 = P1, 1 = P2)
//   current_player       player to move (0 = P1)
//   last_index           index of the most recently placed cell
//   game_over            high while locked in OVER
// -----------------------------------------------------------------------------
module connect4_move_ctrl
    import connect4_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [1:0]  move_col,
    output logic        move_ready,
    output logic        move_ack,
    output logic        move_err,
    input  logic        undo_req,
    output logic        undo_ack,
    input  logic [1:0]  game_status,
    output logic [15:0] game_board,
    output logic [15:0] player_cells,
    output logic        current_player,
    output logic [3:0]  last_index,
    output logic        game_over
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    c4_state_e    state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [15:0]  board_q, board_d;
    logic [15:0]  owner_q, owner_d;
    logic         player_q, player_d;
    logic [3:0]   last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         ready_q, ready_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic         uack_q, uack_d;
    logic         over_q, over_d;

    logic [3:0]   loc_idx_s;
    logic         loc_full_s;
    logic         undo_go_s;

`ifdef CONNECT4_UNDO_EN
    logic         undo_flag_q, undo_flag_d;

    // An undo is only meaningful once a piece has been placed since the last undo.
    assign undo_go_s = undo_req & undo_flag_q;
`else
    logic         unused_undo_req_s;

    assign undo_go_s         = 1'b0;
    assign unused_undo_req_s = undo_req;
`endif

    drop_locator u_drop_locator (
        .col_i   (col_q),
        .board_i (board_q),
        .idx_o   (loc_idx_s),
        .full_o  (loc_full_s)
    );

    // Next-state and next-output computation for the move FSM.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        board_d  = board_q;
        owner_d  = owner_q;
        player_d = player_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        uack_d   = 1'b0;
`ifdef CONNECT4_UNDO_EN
        undo_flag_d = undo_flag_q;
`endif
        if (new_game) begin
            state_d  = ST_IDLE;
            col_d    = 2'd0;
            board_d  = 16'h0000;
            owner_d  = 16'h0000;
            player_d = 1'b0;
            last_d   = 4'd0;
            cnt_d    = '0;
`ifdef CONNECT4_UNDO_EN
            undo_flag_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A move request takes precedence over a simultaneous undo.
                    if (move_valid) begin
                        col_d   = move_col;
                        state_d = ST_LOCATE;
                    end else if (undo_go_s) begin
                        board_d[last_q] = 1'b0;
                        owner_d[last_q] = 1'b0;
                        player_d        = ~player_q;
                        uack_d          = 1'b1;
`ifdef CONNECT4_UNDO_EN
                        undo_flag_d     = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOCATE: begin
                    if (loc_full_s) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        board_d[loc_idx_s] = 1'b1;
                        owner_d[loc_idx_s] = player_q;
                        last_d             = loc_idx_s;
                        player_d           = ~player_q;
                        ack_d              = 1'b1;
                        cnt_d              = '0;
                        state_d            = ST_SETTLE;
`ifdef CONNECT4_UNDO_EN
                        undo_flag_d        = 1'b1;
`endif
                    end
                end
                ST_SETTLE: begin
                    // Give the detector time to register the new board.
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_EVAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    if (game_status != STILL_PLAYING) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // Level outputs are registered from the upcoming state.
        ready_d = (state_d == ST_IDLE);
        over_d  = (state_d == ST_OVER);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            col_q    <= 2'd0;
            board_q  <= 16'h0000;
            owner_q  <= 16'h0000;
            player_q <= 1'b0;
            last_q   <= 4'd0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            uack_q   <= 1'b0;
            over_q   <= 1'b0;
`ifdef CONNECT4_UNDO_EN
            undo_flag_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            board_q  <= board_d;
            owner_q  <= owner_d;
            player_q <= player_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            uack_q   <= uack_d;
            over_q   <= over_d;
`ifdef CONNECT4_UNDO_EN
            undo_flag_q <= undo_flag_d;
`endif
        end
    end

    assign move_ready     = ready_q;
    assign move_ack       = ack_q;
    assign move_err       = err_q;
    assign undo_ack       = uack_q;
    assign game_board     = board_q;
    assign player_cells   = owner_q;
    assign current_player = player_q;
    assign last_index     = last_q;
    assign game_over      = over_q;

endmodule

// File: tb/tb_connect4_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_connect4_move_ctrl
// Directed self-checking bench for connect4_move_ctrl with SETTLE_CYCLES = 1.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_connect4_move_ctrl;

    logic        clk;
    logic        rst_n;
    logic        new_game;
    logic        move_valid;
    logic [1:0]  move_col;
    logic        move_ready;
    logic        move_ack;
    logic        move_err;
    logic        undo_req;
    logic        undo_ack;
    logic [1:0]  game_status;
    logic [15:0] game_board;
    logic [15:0] player_cells;
    logic        current_player;
    logic [3:0]  last_index;
    logic        game_over;

    int checks;
    int errors;

    connect4_move_ctrl #(.SETTLE_CYCLES(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .new_game       (new_game),
        .move_valid     (move_valid),
        .move_col       (move_col),
        .move_ready     (move_ready),
        .move_ack       (move_ack),
        .move_err       (move_err),
        .undo_req       (undo_req),
        .undo_ack       (undo_ack),
        .game_status    (game_status),
        .game_board     (game_board),
        .player_cells   (player_cells),
        .current_player (current_player),
        .last_index     (last_index),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete successful drop; st is the status the detector returns.
    task automatic drop(input logic [1:0] c, input logic [1:0] st);
        move_valid = 1'b1;
        move_col   = c;
        tick();                                   // E0 accept
        chk("accept_ready_low", 16'(move_ready), 16'd0);
        move_valid = 1'b0;
        tick();                                   // E1 board write
        chk("ack_at_e1", 16'(move_ack), 16'd1);
        game_status = st;
        tick();                                   // E2
        chk("ack_one_cycle", 16'(move_ack), 16'd0);
        tick();                                   // E3 eval
        chk("ready_after_e3", 16'(move_ready), 16'(st == 2'b00));
        chk("over_after_e3", 16'(game_over), 16'(st != 2'b00));
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    logic [11:0] ack_seen;

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        new_game    = 1'b0;
        move_valid  = 1'b0;
        move_col    = 2'd0;
        undo_req    = 1'b0;
        game_status = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_board", game_board, 16'h0000);
        chk("rst_cells", player_cells, 16'h0000);
        chk("rst_player", 16'(current_player), 16'd0);
        chk("rst_last", 16'(last_index), 16'd0);
        chk("rst_ready", 16'(move_ready), 16'd1);
        chk("rst_ack", 16'(move_ack), 16'd0);
        chk("rst_err", 16'(move_err), 16'd0);
        chk("rst_uack", 16'(undo_ack), 16'd0);
        chk("rst_over", 16'(game_over), 16'd0);

        // Drops 0,0,1
        drop(2'd0, 2'b00);
        drop(2'd0, 2'b00);
        drop(2'd1, 2'b00);
        chk("t1_board", game_board, 16'h0013);
        chk("t1_cells", player_cells, 16'h0010);
        chk("t1_player", 16'(current_player), 16'd1);
        chk("t1_last", 16'(last_index), 16'd1);

        pulse_new_game();
        chk("ng_board", game_board, 16'h0000);
        chk("ng_player", 16'(current_player), 16'd0);

        // Fill column 2 then overflow it
        for (int i = 0; i < 4; i++) drop(2'd2, 2'b00);
        chk("t2_board", game_board, 16'h4444);
        chk("t2_cells", player_cells, 16'h4040);
        chk("t2_last", 16'(last_index), 16'd14);
        move_valid = 1'b1;
        move_col   = 2'd2;
        tick();                                   // E0
        move_valid = 1'b0;
        tick();                                   // E1
        chk("t2_err", 16'(move_err), 16'd1);
        chk("t2_no_ack", 16'(move_ack), 16'd0);
        chk("t2_ready_e1", 16'(move_ready), 16'd1);
        chk("t2_board_kept", game_board, 16'h4444);
        chk("t2_player_kept", 16'(current_player), 16'd0);
        tick();
        chk("t2_err_pulse", 16'(move_err), 16'd0);

        // P1 wins on the bottom row
        pulse_new_game();
        drop(2'd0, 2'b00);
        drop(2'd0, 2'b00);
        drop(2'd1, 2'b00);
        drop(2'd1, 2'b00);
        drop(2'd2, 2'b00);
        drop(2'd2, 2'b00);
        drop(2'd3, 2'b01);
        chk("t3_board", game_board, 16'h007F);
        chk("t3_cells", player_cells, 16'h0070);
        chk("t3_player", 16'(current_player), 16'd1);
        chk("t3_ready", 16'(move_ready), 16'd0);
        move_valid = 1'b1;
        move_col   = 2'd3;
        repeat (5) tick();
        chk("t3_locked_board", game_board, 16'h007F);
        chk("t3_locked_ack", 16'(move_ack), 16'd0);
        chk("t3_locked_over", 16'(game_over), 16'd1);
        new_game = 1'b1;                          // overrides the held move
        tick();
        new_game    = 1'b0;
        move_valid  = 1'b0;
        game_status = 2'b00;
        chk("t3_clr_board", game_board, 16'h0000);
        chk("t3_clr_cells", player_cells, 16'h0000);
        chk("t3_clr_player", 16'(current_player), 16'd0);
        chk("t3_clr_last", 16'(last_index), 16'd0);
        chk("t3_clr_over", 16'(game_over), 16'd0);
        chk("t3_clr_ready", 16'(move_ready), 16'd1);

        // Held move_valid: one accept every 4 cycles
        move_valid = 1'b1;
        move_col   = 2'd1;
        ack_seen   = 12'd0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ack_seen[i] = move_ack;
        end
        move_valid = 1'b0;
        chk("t4_ack_pattern", 16'(ack_seen), 16'h0222);
        chk("t4_board", game_board, 16'h0222);
        chk("t4_cells", player_cells, 16'h0020);
        chk("t4_ready", 16'(move_ready), 16'd1);
        tick();
        chk("t4_no_extra", game_board, 16'h0222);

        // Reset during SETTLE
        pulse_new_game();
        move_valid = 1'b1;
        move_col   = 2'd3;
        tick();                                   // E0
        move_valid = 1'b0;
        tick();                                   // E1, now in SETTLE
        chk("t5_ack", 16'(move_ack), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_board", game_board, 16'h0000);
        chk("t5_cells", player_cells, 16'h0000);
        chk("t5_player", 16'(current_player), 16'd0);
        chk("t5_last", 16'(last_index), 16'd0);
        chk("t5_ack_clr", 16'(move_ack), 16'd0);
        chk("t5_ready", 16'(move_ready), 16'd1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t5_idle_ready", 16'(move_ready), 16'd1);
        chk("t5_idle_board", game_board, 16'h0000);

        // Undo
        drop(2'd3, 2'b00);
        chk("t6_pre_board", game_board, 16'h0008);
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
`ifdef CONNECT4_UNDO_EN
        chk("t6_uack", 16'(undo_ack), 16'd1);
        chk("t6_board", game_board, 16'h0000);
        chk("t6_player", 16'(current_player), 16'd0);
        tick();
        chk("t6_uack_pulse", 16'(undo_ack), 16'd0);
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
        chk("t6_second_uack", 16'(undo_ack), 16'd0);
        chk("t6_second_board", game_board, 16'h0000);
`else
        chk("t6_uack_tied", 16'(undo_ack), 16'd0);
        chk("t6_board_kept", game_board, 16'h0008);
        chk("t6_player_kept", 16'(current_player), 16'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
